speed_change_pulser: RTL

- Sits directly downstream of the clock-control core; converts its per-decision speed-change requests into FINC/FDEC pulses on the board pins that drive the clock synthesizer.
- Enforces the synthesizer's minimum pulse width and the minimum gap between consecutive pulses.
- Back-pressures the clock-control core with a valid/ready handshake while a pulse or its gap is in progress.

---
 rtl/speed_change_pkg.sv | 23 ++
 rtl/pulse_timer.sv | 35 +++
 rtl/speed_change_pulser.sv | 132 +++++++++++++
 3 files changed

// File: rtl/speed_change_pkg.sv
// Shared types for the clock-control path: speed-change request codes and pulser FSM states.
// No logic; the timer width helper is evaluated at elaboration.
// Backpressure: not applicable.
package speed_change_pkg;

    typedef enum logic [1:0] {
        NO_CHANGE = 2'b00,
        SPEED_UP  = 2'b01,
        SLOW_DOWN = 2'b10
    } speed_change_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pulser_state_t;

    // Bits needed to hold the larger of the two phase lengths.
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag, shared by the PULSE and GAP phases.
// Latency: a load takes effect next cycle; otherwise it counts down one per cycle and holds at zero.
// Backpressure: none; a load always wins over the decrement.
module pulse_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_vld_i,
    input  logic [WIDTH-1:0] load_dat_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_vld_i) begin
            cnt_d = load_dat_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/speed_change_pulser.sv
// Turns accepted speed-change requests into fixed-width FINC/FDEC pulses followed by a mandatory gap.
// Latency: accept in cycle N -> pulse N+1..N+PULSE_CYCLES, ready again at N+PULSE_CYCLES+GAP_CYCLES+1.
// Backpressure: req_ready low during PULSE and GAP; SPEED_STEP_COUNT_EN adds the saturating step_count.
module speed_change_pulser
    import speed_change_pkg::*;
#(
    parameter int PULSE_CYCLES = 30,
    parameter int GAP_CYCLES   = 300,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                          clkInternal,
    input  logic                          rstInternal,
    input  logic                          req_valid,
    input  logic [1:0]                    req_speed,
    output logic                          req_ready,
    output logic                          FINC,
    output logic                          FDEC,
    output logic                          busy
`ifdef SPEED_STEP_COUNT_EN
    ,
    output logic signed [COUNT_WIDTH-1:0] step_count
`endif
);

    localparam int TW = timer_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    pulser_state_t state_q, state_d;
    logic          dir_up_q, dir_up_d;
    logic          finc_q, fdec_q, busy_q;
    logic          tmr_load;
    logic [TW-1:0] tmr_dat;
    logic          tmr_zero;
    logic          accept, is_up, is_dn;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign is_up     = (req_speed == SPEED_UP);
    assign is_dn     = (req_speed == SLOW_DOWN);

    pulse_timer #(.WIDTH(TW)) u_timer (
        .clk_i      (clkInternal),
        .rst_i      (rstInternal),
        .load_vld_i (tmr_load),
        .load_dat_i (tmr_dat),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        tmr_load = 1'b0;
        tmr_dat  = '0;
        case (state_q)
            IDLE: begin
                // Codes 00 and 11 are consumed here without producing a pulse.
                if (accept && (is_up || is_dn)) begin
                    tmr_load = 1'b1;
                    tmr_dat  = PULSE_LOAD;
                    dir_up_d = is_up;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_dat  = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they leave a flop aligned with the state.
    always_ff @(posedge clkInternal) begin
        if (rstInternal) begin
            state_q  <= IDLE;
            dir_up_q <= 1'b0;
            finc_q   <= 1'b0;
            fdec_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            finc_q   <= (state_d == PULSE) && dir_up_d;
            fdec_q   <= (state_d == PULSE) && !dir_up_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign FINC = finc_q;
    assign FDEC = fdec_q;
    assign busy = busy_q;

`ifdef SPEED_STEP_COUNT_EN
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

    logic signed [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && is_up && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end else if (accept && is_dn && (cnt_q != CNT_MIN)) begin
            cnt_d = cnt_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clkInternal) begin
        if (rstInternal) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_count = cnt_q;
`else
    // Counter width only matters when the step counter is built in.
    logic cfg_unused;
    assign cfg_unused = (COUNT_WIDTH > 0);
`endif

endmodule
